// File: rtl/a429_pkg.sv
// rtl/a429_pkg.sv - shared ARINC429 constants for the receive path
package a429_pkg;

  localparam int A429_WORD_W  = 32;
  localparam int A429_LBL_LSB = 0;
  localparam int A429_LBL_MSB = 7;
  localparam int A429_LBL_W   = A429_LBL_MSB - A429_LBL_LSB + 1;
  localparam int A429_DEPTH   = 32;
  localparam int A429_REJ_W   = 16;

  typedef logic [A429_LBL_W-1:0]  a429_label_t;
  typedef logic [A429_WORD_W-1:0] a429_word_t;

  function automatic a429_label_t a429_label(input a429_word_t w);
    return w[A429_LBL_MSB:A429_LBL_LSB];
  endfunction

endpackage

// File: rtl/a429_sync_fifo.sv
// rtl/a429_sync_fifo.sv - first-word-fall-through FIFO with registered flags and count
module a429_sync_fifo
  import a429_pkg::*;
#(
  parameter int DEPTH = A429_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = A429_WORD_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic [DW-1:0] di_i,
  input  logic          rd_i,
  output logic [DW-1:0] do_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   cnt_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_nxt, rd_nxt, cnt_nxt;
  logic          do_wr, do_rd;
  logic          head_bypass;

  assign do_wr = wr_i && !full_o && !flush_i;
  assign do_rd = rd_i && !empty_o && !flush_i;

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush_i) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (do_wr) wr_nxt = wr_ptr + 1'b1;
      if (do_rd) rd_nxt = rd_ptr + 1'b1;
    end
    cnt_nxt = wr_nxt - rd_nxt;
  end

  // The incoming word becomes the next head when it lands where the read pointer will point.
  assign head_bypass = do_wr && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]);

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= di_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_o   <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
      do_o    <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      cnt_o   <= cnt_nxt;
      empty_o <= (cnt_nxt == '0);
      full_o  <= (cnt_nxt == FULL_CNT);
      if (flush_i)
        do_o <= '0;
      else if (cnt_nxt != '0)
        do_o <= head_bypass ? di_i : mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/a429_rx_fifo.sv
// rtl/a429_rx_fifo.sv - ARINC429 receive FIFO with label accept filter, overflow and reject counters
module a429_rx_fifo
  import a429_pkg::*;
#(
  parameter int DEPTH = A429_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rf_wr,
  input  logic [31:0]           rf_di,
  output logic                  rf_fl,
  input  logic                  rd_i,
  output logic [31:0]           rd_do,
  output logic                  empty_o,
  output logic [AW:0]           cnt_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i,
  input  logic                  flush_i,
  input  logic                  lbl_ena_i,
  input  logic                  lbl_we_i,
  input  logic [7:0]            lbl_addr_i,
  input  logic                  lbl_di_i,
  output logic [A429_REJ_W-1:0] rej_cnt_o
);

  logic [(1<<A429_LBL_W)-1:0] lbl_tbl;
  logic                       accept;
  logic                       acc_wr;
  logic                       rej_wr;
  logic                       ovf_evt;

  // Table lookup uses the registered entry, so a same-cycle table write affects only later words.
  assign accept  = !lbl_ena_i || lbl_tbl[a429_label(rf_di)];
  assign acc_wr  = rf_wr && !flush_i && accept;
  assign rej_wr  = rf_wr && !flush_i && !accept;
  assign ovf_evt = acc_wr && rf_fl;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lbl_tbl   <= '1;
      rej_cnt_o <= '0;
      ovf_o     <= 1'b0;
    end else begin
      if (lbl_we_i) lbl_tbl[lbl_addr_i] <= lbl_di_i;
      if (rej_wr && (rej_cnt_o != '1)) rej_cnt_o <= rej_cnt_o + 1'b1;
      if (ovf_evt)
        ovf_o <= 1'b1;
      else if (ovf_clr_i)
        ovf_o <= 1'b0;
    end
  end

  a429_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (A429_WORD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .wr_i    (acc_wr),
    .di_i    (rf_di),
    .rd_i    (rd_i),
    .do_o    (rd_do),
    .empty_o (empty_o),
    .full_o  (rf_fl),
    .cnt_o   (cnt_o)
  );

endmodule

// File: tb/tb_a429_rx_fifo.sv
// tb/tb_a429_rx_fifo.sv - directed self-checking bench for a429_rx_fifo
module tb_a429_rx_fifo;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rf_wr;
  logic [31:0] rf_di;
  logic        rf_fl;
  logic        rd_i;
  logic [31:0] rd_do;
  logic        empty_o;
  logic [AW:0] cnt_o;
  logic        ovf_o;
  logic        ovf_clr_i;
  logic        flush_i;
  logic        lbl_ena_i;
  logic        lbl_we_i;
  logic [7:0]  lbl_addr_i;
  logic        lbl_di_i;
  logic [15:0] rej_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  a429_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rf_wr      (rf_wr),
    .rf_di      (rf_di),
    .rf_fl      (rf_fl),
    .rd_i       (rd_i),
    .rd_do      (rd_do),
    .empty_o    (empty_o),
    .cnt_o      (cnt_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i),
    .flush_i    (flush_i),
    .lbl_ena_i  (lbl_ena_i),
    .lbl_we_i   (lbl_we_i),
    .lbl_addr_i (lbl_addr_i),
    .lbl_di_i   (lbl_di_i),
    .rej_cnt_o  (rej_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rf_wr = 1'b0; rd_i = 1'b0; ovf_clr_i = 1'b0; flush_i = 1'b0; lbl_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; idle(); rf_di = '0; lbl_ena_i = 1'b0; lbl_addr_i = '0; lbl_di_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    n_checks++; if (empty_o !== 1'b1)  begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty_o); end
    n_checks++; if (rf_fl !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %0b want 0", rf_fl); end
    n_checks++; if (cnt_o !== 6'd0)    begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt_o); end
    n_checks++; if (ovf_o !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf_o); end
    n_checks++; if (rej_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_rej got %0d want 0", rej_cnt_o); end
    n_checks++; if (rd_do !== 32'd0)   begin n_fail++; $display("FAIL reset_rd_do got %h want 0", rd_do); end
  endtask

  task automatic test_basic();
    logic [31:0] words [3];
    words[0] = 32'h0000_00A5; words[1] = 32'h1234_5678; words[2] = 32'hFFFF_FF01;
    rd_i = 1'b1; tick(); rd_i = 1'b0;
    n_checks++; if (cnt_o !== 6'd0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL rd_empty cnt %0d empty %0b want 0 1", cnt_o, empty_o); end
    for (int i = 0; i < 3; i++) begin
      rf_wr = 1'b1; rf_di = words[i]; tick();
      if (i == 0) begin
        n_checks++; if (rd_do !== words[0] || empty_o !== 1'b0) begin n_fail++; $display("FAIL fwft_first got %h empty %0b want %h 0", rd_do, empty_o, words[0]); end
      end
    end
    rf_wr = 1'b0;
    n_checks++; if (cnt_o !== 6'd3) begin n_fail++; $display("FAIL basic_cnt got %0d want 3", cnt_o); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rd_do !== words[i]) begin n_fail++; $display("FAIL basic_pop%0d got %h want %h", i, rd_do, words[i]); end
      rd_i = 1'b1; tick(); rd_i = 1'b0;
    end
    n_checks++; if (empty_o !== 1'b1 || cnt_o !== 6'd0) begin n_fail++; $display("FAIL basic_drained empty %0b cnt %0d want 1 0", empty_o, cnt_o); end
  endtask

  task automatic test_label_filter();
    lbl_ena_i = 1'b1;
    // table write and word in the same cycle: the old entry (accept) applies
    lbl_we_i = 1'b1; lbl_addr_i = 8'h31; lbl_di_i = 1'b0;
    rf_wr = 1'b1; rf_di = 32'hAAAA_0031; tick();
    lbl_we_i = 1'b0;
    rf_di = 32'hBBBB_0031; tick();
    rf_di = 32'hCCCC_0032; tick();
    rf_wr = 1'b0;
    n_checks++; if (cnt_o !== 6'd2) begin n_fail++; $display("FAIL lbl_cnt got %0d want 2", cnt_o); end
    n_checks++; if (rej_cnt_o !== 16'd1) begin n_fail++; $display("FAIL lbl_rej got %0d want 1", rej_cnt_o); end
    n_checks++; if (rd_do !== 32'hAAAA_0031) begin n_fail++; $display("FAIL lbl_head0 got %h want aaaa0031", rd_do); end
    rd_i = 1'b1; tick(); rd_i = 1'b0;
    n_checks++; if (rd_do !== 32'hCCCC_0032) begin n_fail++; $display("FAIL lbl_head1 got %h want cccc0032", rd_do); end
    rd_i = 1'b1; tick(); rd_i = 1'b0;
    lbl_ena_i = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      rf_wr = 1'b1; rf_di = 32'h100 + i; tick();
    end
    rf_wr = 1'b0;
    n_checks++; if (cnt_o !== 6'd32 || rf_fl !== 1'b1) begin n_fail++; $display("FAIL full cnt %0d fl %0b want 32 1", cnt_o, rf_fl); end
    n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b want 0", ovf_o); end
    rf_wr = 1'b1; rf_di = 32'h120; tick(); rf_wr = 1'b0;
    n_checks++; if (ovf_o !== 1'b1 || cnt_o !== 6'd32) begin n_fail++; $display("FAIL ovf_set ovf %0b cnt %0d want 1 32", ovf_o, cnt_o); end
    // full write with simultaneous pop: word dropped, pop still happens
    rf_wr = 1'b1; rf_di = 32'h121; rd_i = 1'b1; tick(); rf_wr = 1'b0; rd_i = 1'b0;
    n_checks++; if (cnt_o !== 6'd31 || rf_fl !== 1'b0 || rd_do !== 32'h101) begin n_fail++; $display("FAIL full_rdwr cnt %0d fl %0b head %h want 31 0 101", cnt_o, rf_fl, rd_do); end
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %0b want 0", ovf_o); end
    rf_wr = 1'b1; rf_di = 32'h200; tick();
    rf_di = 32'h201; ovf_clr_i = 1'b1; tick(); rf_wr = 1'b0; ovf_clr_i = 1'b0;
    n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_race got %0b want 1", ovf_o); end
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] exp;
      exp = (i < 31) ? 32'h101 + i : 32'h200;
      n_checks++; if (rd_do !== exp) begin n_fail++; $display("FAIL ovf_drain%0d got %h want %h", i, rd_do, exp); end
      rd_i = 1'b1; tick(); rd_i = 1'b0;
    end
    n_checks++; if (empty_o !== 1'b1 || ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_end empty %0b ovf %0b want 1 0", empty_o, ovf_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      rf_wr = 1'b1; rf_di = 32'h300 + i; tick();
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (rd_do !== 32'h300 + k) begin n_fail++; $display("FAIL b2b_head%0d got %h want %h", k, rd_do, 32'h300 + k); end
      rf_wr = 1'b1; rf_di = 32'h305 + k; rd_i = 1'b1; tick();
      n_checks++; if (cnt_o !== 6'd5) begin n_fail++; $display("FAIL b2b_cnt%0d got %0d want 5", k, cnt_o); end
    end
    rf_wr = 1'b0; rd_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (rd_do !== 32'h30A + k) begin n_fail++; $display("FAIL b2b_tail%0d got %h want %h", k, rd_do, 32'h30A + k); end
      rd_i = 1'b1; tick(); rd_i = 1'b0;
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 7; i++) begin
      rf_wr = 1'b1; rf_di = 32'h400 + i; tick();
    end
    rf_wr = 1'b0;
    n_checks++; if (cnt_o !== 6'd7) begin n_fail++; $display("FAIL pre_flush_cnt got %0d want 7", cnt_o); end
    flush_i = 1'b1; rf_wr = 1'b1; rf_di = 32'h4FF; rd_i = 1'b1; tick();
    flush_i = 1'b0; rf_wr = 1'b0; rd_i = 1'b0;
    n_checks++; if (cnt_o !== 6'd0 || empty_o !== 1'b1 || rf_fl !== 1'b0) begin n_fail++; $display("FAIL flush cnt %0d empty %0b fl %0b want 0 1 0", cnt_o, empty_o, rf_fl); end
    n_checks++; if (rej_cnt_o !== 16'd1) begin n_fail++; $display("FAIL flush_rej got %0d want 1", rej_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      rf_wr = 1'b1; rf_di = 32'h500 + i; tick();
    end
    rst_i = 1'b1; rf_wr = 1'b1; rf_di = 32'h5FF; tick();
    rst_i = 1'b0; rf_wr = 1'b0;
    n_checks++; if (empty_o !== 1'b1 || rf_fl !== 1'b0 || cnt_o !== 6'd0) begin n_fail++; $display("FAIL rst_mid empty %0b fl %0b cnt %0d want 1 0 0", empty_o, rf_fl, cnt_o); end
    n_checks++; if (ovf_o !== 1'b0 || rej_cnt_o !== 16'd0 || rd_do !== 32'd0) begin n_fail++; $display("FAIL rst_mid ovf %0b rej %0d rd_do %h want 0 0 0", ovf_o, rej_cnt_o, rd_do); end
    lbl_ena_i = 1'b1; rf_wr = 1'b1; rf_di = 32'h0000_0031; tick(); rf_wr = 1'b0;
    n_checks++; if (cnt_o !== 6'd1 || rd_do !== 32'h31) begin n_fail++; $display("FAIL rst_table cnt %0d head %h want 1 31", cnt_o, rd_do); end
    lbl_ena_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_label_filter();
    test_overflow();
    test_back_to_back();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a429_rx_fifo.md
A429_RX_FIFO -- requirements
Module: a429_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning receive word storage depth; legal values are powers of two, 4..256.
REQ-002 SHALL have parameter AW, default log2(DEPTH), meaning pointer width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rf_wr, input, 1 bit: one-cycle write strobe from the ARINC429 receiver.
REQ-006 SHALL have port rf_di, input, 32 bits: received word; label in [7:0], SDI in [9:8] position per receiver mapping.
REQ-007 SHALL have port rf_fl, output, 1 bit: FIFO full, returned to the receiver.
REQ-008 SHALL have port rd_i, input, 1 bit: host pop strobe.
REQ-009 SHALL have port rd_do, output, 32 bits: head word, first-word-fall-through.
REQ-010 SHALL have port empty_o, output, 1 bit: FIFO empty; rd_do is valid when low.
REQ-011 SHALL have port cnt_o, output, AW+1 bits: stored word count, 0..DEPTH.
REQ-012 SHALL have port ovf_o, output, 1 bit: sticky overflow flag.
REQ-013 SHALL have port ovf_clr_i, input, 1 bit: clears ovf_o.
REQ-014 SHALL have port flush_i, input, 1 bit: discards all stored words.
REQ-015 SHALL have port lbl_ena_i, input, 1 bit: label filter enable.
REQ-016 SHALL have ports lbl_we_i (1), lbl_addr_i (8), lbl_di_i (1), inputs: label accept-table write port.
REQ-017 SHALL have port rej_cnt_o, output, 16 bits: saturating count of label-rejected words.

Function
REQ-018 SHALL accept a word on rf_wr when lbl_ena_i=0, or when the accept-table entry at rf_di[7:0] is 1; otherwise it SHALL reject the word.
REQ-019 SHALL increment rej_cnt_o by one per rejected word, saturating at 0xFFFF.
REQ-020 SHALL apply an accept-table write from the cycle after lbl_we_i, so a same-cycle rf_wr uses the old entry.
REQ-021 SHALL store an accepted word when not full; the word SHALL appear on rd_do one cycle later if the FIFO was empty.
REQ-022 SHALL drop an accepted word arriving while full, and set ovf_o in the next cycle; the drop applies even with a same-cycle rd_i.
REQ-023 SHALL pop on rd_i when empty_o=0, with rd_do showing the next word on the following cycle; rd_i while empty SHALL be ignored.
REQ-024 SHALL store and pop in the same cycle when neither empty nor full, leaving cnt_o unchanged.
REQ-025 SHALL store the word and ignore rd_i on simultaneous write and read while empty.
REQ-026 SHALL register rf_fl, empty_o and cnt_o, all consistent with pointer state after each edge; rf_fl=1 exactly when cnt_o=DEPTH.
REQ-027 SHALL wrap pointers modulo DEPTH, using an extra MSB to distinguish full from empty.
REQ-028 SHALL, on flush_i, zero pointers and cnt_o next cycle and ignore same-cycle rf_wr and rd_i; ovf_o, rej_cnt_o and the table are unaffected.
REQ-029 SHALL clear ovf_o on ovf_clr_i; a same-cycle overflow event SHALL win and leave ovf_o set.

Reset
REQ-030 SHALL on rst_i set empty_o=1, rf_fl=0, cnt_o=0, ovf_o=0, rej_cnt_o=0, pointers=0, and all 256 accept-table entries to 1.
REQ-031 SHALL set rd_do to 0 after reset; storage RAM contents are not reset.
REQ-032 SHALL give rst_i priority over every other input; reset mid-operation discards stored words.

Structure
REQ-033 SHALL take label field position [7:0], default DEPTH, and the rej_cnt_o width from the shared a429 constants package.
REQ-034 SHALL implement storage and pointers in one sub-module, a429_sync_fifo; the label filter, counters and flags SHALL live in a429_rx_fifo.

Verification
REQ-035 Write 0x000000A5, 0x12345678, 0xFFFFFF01 with lbl_ena_i=0 -> cnt_o=3, and the same three words pop in order.
REQ-036 Clear table entry 0x31 and set lbl_ena_i=1, then write labels 0x31 and 0x32 -> only the 0x32 word is stored, rej_cnt_o=1.
REQ-037 Write DEPTH+1 words with no reads -> rf_fl=1 at count 32, the 33rd word is dropped, ovf_o=1; ovf_clr_i then gives ovf_o=0.
REQ-038 Hold rd_i and rf_wr together for 10 cycles from cnt_o=5 -> cnt_o stays 5, and output data matches order.
REQ-039 Assert flush_i with cnt_o=7, together with rf_wr -> next cycle cnt_o=0, empty_o=1; rst_i mid-stream -> all REQ-030 values.
